// File: rtl/tl_pkg.sv
// Shared light codes, state encodings and sizing helpers for the timed traffic-light controller.
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;
    localparam logic [1:0] LEFT   = 2'b11;

    localparam logic [3:0] ST_AG  = 4'd0;
    localparam logic [3:0] ST_AY  = 4'd1;
    localparam logic [3:0] ST_AL  = 4'd2;
    localparam logic [3:0] ST_ALY = 4'd3;
    localparam logic [3:0] ST_BG  = 4'd4;
    localparam logic [3:0] ST_BY  = 4'd5;
    localparam logic [3:0] ST_BL  = 4'd6;
    localparam logic [3:0] ST_BLY = 4'd7;
    localparam logic [3:0] ST_PED = 4'd8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold max_val-1, never less than one.
    function automatic int width_for(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < max_val) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Purpose: per-phase cycle counter with synchronous clear, saturating at all-ones.
// Latency: count visible one cycle after the edge it was updated on.
// Backpressure: none; en simply freezes the count.
module tl_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tl_cntr_timed.sv
// Purpose: timed two-road traffic-light Moore FSM with optional left arrows; TL_PED_EN adds a walk phase.
// Latency: lights decode straight from the state register, changing on the edge the state changes.
// Backpressure: none; sensors are sampled only on the cycle a phase decision is made.
module tl_cntr_timed
    import tl_pkg::*;
#(
    parameter int MIN_GREEN     = 4,
    parameter int MAX_GREEN     = 10,
    parameter int YELLOW_CYCLES = 2,
    parameter int LEFT_CYCLES   = 3,
    parameter int PED_CYCLES    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       Tal,
    input  logic       Tbl,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk,
    output logic [3:0] state
);

    localparam int TW = width_for(max4(MAX_GREEN, PED_CYCLES, LEFT_CYCLES, YELLOW_CYCLES));

    localparam logic [TW-1:0] MIN_END  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_END  = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_END  = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] LEFT_END = TW'(LEFT_CYCLES - 1);
    localparam logic [TW-1:0] PED_END  = TW'(PED_CYCLES - 1);

    logic [3:0]    state_q;
    logic [3:0]    state_nxt;
    logic [TW-1:0] cnt;
    logic          ped_lat;
    logic [3:0]    wrap_tgt;

    tl_phase_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (state_nxt != state_q),
        .en    (1'b1),
        .cnt   (cnt)
    );

`ifdef TL_PED_EN
    // Entry into PED wins over a same-cycle request, so a press during the handoff is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_lat <= 1'b0;
        end else if ((state_nxt == ST_PED) && (state_q != ST_PED)) begin
            ped_lat <= 1'b0;
        end else if (ped_req && (state_q != ST_PED)) begin
            ped_lat <= 1'b1;
        end
    end
`else
    logic ped_unused;
    assign ped_unused = ped_req;
    assign ped_lat    = 1'b0;
`endif

    assign wrap_tgt = ped_lat ? ST_PED : ST_AG;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_AG;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_AG:  if (((cnt >= MIN_END) && !Ta) || (cnt == MAX_END)) state_nxt = ST_AY;
            ST_AY:  if (cnt == YEL_END) state_nxt = Tal ? ST_AL : ST_BG;
            ST_AL:  if (cnt == LEFT_END) state_nxt = ST_ALY;
            ST_ALY: if (cnt == YEL_END) state_nxt = ST_BG;
            ST_BG:  if (((cnt >= MIN_END) && !Tb) || (cnt == MAX_END)) state_nxt = ST_BY;
            ST_BY:  if (cnt == YEL_END) state_nxt = Tbl ? ST_BL : wrap_tgt;
            ST_BL:  if (cnt == LEFT_END) state_nxt = ST_BLY;
            ST_BLY: if (cnt == YEL_END) state_nxt = wrap_tgt;
            ST_PED: if (cnt == PED_END) state_nxt = ST_AG;
            default: state_nxt = ST_AG;
        endcase
    end

    always_comb begin
        La   = RED;
        Lb   = RED;
        walk = 1'b0;
        case (state_q)
            ST_AG:  La = GREEN;
            ST_AY:  La = YELLOW;
            ST_AL:  La = LEFT;
            ST_ALY: La = YELLOW;
            ST_BG:  Lb = GREEN;
            ST_BY:  Lb = YELLOW;
            ST_BL:  Lb = LEFT;
            ST_BLY: Lb = YELLOW;
`ifdef TL_PED_EN
            ST_PED: walk = 1'b1;
`endif
            default: begin
                La = RED;
                Lb = RED;
            end
        endcase
    end

    assign state = state_q;

endmodule
